// File: rtl/sr_excite_driver.sv
// Write-side controller for an external SR flip-flop bank: pulses S/R for one cycle, waits SETTLE cycles, then verifies q_fb.
// done/err arrive SETTLE+1 cycles per attempt after accept; tgt_ready is high only in IDLE.
module sr_excite_driver #(
  parameter int WIDTH     = 8,
  parameter int SETTLE    = 1,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tgt,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask,
  output logic [3:0]       retry_cnt
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] s_q, r_q;
  logic [WIDTH-1:0] err_mask_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       retry_q;
  logic             done_q, err_q;

  logic [WIDTH-1:0] exc_tgt;
  logic [WIDTH-1:0] s_d, r_d;
  logic             mismatch;

  // Excitation uses the incoming word in IDLE and the captured word on retries;
  // t & ~q and ~t & q can never both be 1, so S=R=1 is impossible by construction.
  always_comb begin
    exc_tgt = (state_q == S_IDLE) ? tgt : tgt_q;
    s_d     = exc_tgt & ~q_fb;
    r_d     = ~exc_tgt & q_fb;
  end

  assign mismatch = (q_fb != tgt_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tgt_q      <= '0;
      s_q        <= '0;
      r_q        <= '0;
      err_mask_q <= '0;
      cnt_q      <= '0;
      retry_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tgt_valid) begin
            tgt_q      <= tgt;
            retry_q    <= '0;
            err_mask_q <= '0;
            s_q        <= s_d;
            r_q        <= r_d;
            state_q    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          s_q     <= '0;
          r_q     <= '0;
          cnt_q   <= CW'(SETTLE - 1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!mismatch) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (retry_q < 4'(MAX_RETRY)) begin
            retry_q <= retry_q + 4'd1;
            s_q     <= s_d;
            r_q     <= r_d;
            state_q <= S_DRIVE;
          end else begin
            err_q      <= 1'b1;
            err_mask_q <= q_fb ^ tgt_q;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tgt_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign s_out     = s_q;
  assign r_out     = r_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_mask  = err_mask_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_sr_excite_driver.sv
// Directed bench for sr_excite_driver with a behavioural SR bank (settable ignore-once and stuck-at-0 bits).
module tb_sr_excite_driver;

  logic       clk;
  logic       rst;
  logic [7:0] tgt;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [7:0] s_out;
  logic [7:0] r_out;
  logic [7:0] q_fb;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] err_mask;
  logic [3:0] retry_cnt;

  int checks;
  int failures;
  int overlap_cnt;
  int both_cnt;

  logic [7:0] bank_q, ign_q, stuck_q;
  logic       preset_vld;
  logic [7:0] preset_q, preset_ign, preset_stuck;

  sr_excite_driver #(.WIDTH(8), .SETTLE(1), .MAX_RETRY(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .tgt      (tgt),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .s_out    (s_out),
    .r_out    (r_out),
    .q_fb     (q_fb),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_mask (err_mask),
    .retry_cnt(retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SR bank: Q follows S/R on the next edge; ign_q bits drop their first set pulse, stuck_q bits stay 0
  always @(posedge clk) begin
    if (preset_vld) begin
      bank_q  <= preset_q;
      ign_q   <= preset_ign;
      stuck_q <= preset_stuck;
    end else begin
      bank_q <= ((bank_q | (s_out & ~ign_q)) & ~r_out) & ~stuck_q;
      ign_q  <= ign_q & ~s_out;
    end
  end
  assign q_fb = bank_q;

  always @(negedge clk) begin
    if (rst === 1'b1 && (s_out & r_out) != 8'h00) overlap_cnt++;
    if (done === 1'b1 && err === 1'b1) both_cnt++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic preset_bank(input logic [7:0] q, input logic [7:0] ign, input logic [7:0] stuck);
    preset_q     = q;
    preset_ign   = ign;
    preset_stuck = stuck;
    preset_vld   = 1'b1;
    step();
    preset_vld   = 1'b0;
  endtask

  // Accepts one word, then samples every cycle until done/err or a 40-cycle bound
  task automatic run_word(input logic [7:0] t, output int done_cyc, output int err_cyc,
                          output int s_cyc, output int strobe_cyc,
                          output logic [7:0] first_s, output logic [7:0] first_r,
                          output logic first_busy);
    tgt       = t;
    tgt_valid = 1'b1;
    step();
    tgt_valid = 1'b0;
    tgt       = 8'h5A;
    done_cyc = -1; err_cyc = -1; s_cyc = 0; strobe_cyc = 0;
    first_s = 8'h00; first_r = 8'h00; first_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) step();
      if (s_out != 8'h00) s_cyc++;
      if (s_out != 8'h00 || r_out != 8'h00) strobe_cyc++;
      if (c == 0) begin
        first_s = s_out; first_r = r_out; first_busy = busy;
      end
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (err === 1'b1 && err_cyc < 0) err_cyc = c;
      if (done === 1'b1 || err === 1'b1) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; tgt = 8'hFF; tgt_valid = 1'b1;
    step(); step();
    checks++; if (tgt_ready !== 1'b1) begin failures++; $display("FAIL reset_tgt_ready got=%b exp=1", tgt_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (s_out !== 8'h00 || r_out !== 8'h00) begin failures++; $display("FAIL reset_strobes got s=%h r=%h exp=00/00", s_out, r_out); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_done_err got=%b%b exp=00", done, err); end
    checks++; if (retry_cnt !== 4'd0 || err_mask !== 8'h00) begin failures++; $display("FAIL reset_regs got retry=%0d mask=%h exp=0/00", retry_cnt, err_mask); end
    tgt_valid = 1'b0;
    rst = 1'b1;
    preset_vld = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_no_accept got busy=%b exp=0", busy); end
  endtask

  task automatic test_basic;
    int dc, ec, sc, stc; logic [7:0] fs, fr; logic fb;
    preset_bank(8'h0F, 8'h00, 8'h00);
    run_word(8'hF0, dc, ec, sc, stc, fs, fr, fb);
    checks++; if (fs !== 8'hF0 || fr !== 8'h0F) begin failures++; $display("FAIL basic_excite got s=%h r=%h exp=F0/0F", fs, fr); end
    checks++; if (sc !== 1) begin failures++; $display("FAIL basic_pulse_cycles got=%0d exp=1", sc); end
    checks++; if (dc !== 2) begin failures++; $display("FAIL basic_done_latency got=%0d exp=2", dc); end
    checks++; if (retry_cnt !== 4'd0) begin failures++; $display("FAIL basic_retry got=%0d exp=0", retry_cnt); end
    checks++; if (bank_q !== 8'hF0) begin failures++; $display("FAIL basic_bank_q got=%h exp=F0", bank_q); end
    checks++; if (tgt_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_in_done got=%b exp=1", tgt_ready); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_one_cycle got=%b exp=0", done); end
  endtask

  task automatic test_no_change;
    int dc, ec, sc, stc; logic [7:0] fs, fr; logic fb;
    preset_bank(8'hA5, 8'h00, 8'h00);
    run_word(8'hA5, dc, ec, sc, stc, fs, fr, fb);
    checks++; if (fb !== 1'b1) begin failures++; $display("FAIL nochange_drive_busy got=%b exp=1", fb); end
    checks++; if (stc !== 0) begin failures++; $display("FAIL nochange_strobes got=%0d exp=0", stc); end
    checks++; if (dc !== 2) begin failures++; $display("FAIL nochange_done_latency got=%0d exp=2", dc); end
  endtask

  task automatic test_retry;
    int dc, ec, sc, stc; logic [7:0] fs, fr; logic fb;
    preset_bank(8'h00, 8'h08, 8'h00);
    run_word(8'h08, dc, ec, sc, stc, fs, fr, fb);
    checks++; if (fs !== 8'h08) begin failures++; $display("FAIL retry_first_s got=%h exp=08", fs); end
    checks++; if (sc !== 2) begin failures++; $display("FAIL retry_pulses got=%0d exp=2", sc); end
    checks++; if (dc !== 4) begin failures++; $display("FAIL retry_done_latency got=%0d exp=4", dc); end
    checks++; if (retry_cnt !== 4'd1) begin failures++; $display("FAIL retry_cnt got=%0d exp=1", retry_cnt); end
  endtask

  task automatic test_exhausted;
    int dc, ec, sc, stc; logic [7:0] fs, fr; logic fb;
    preset_bank(8'h00, 8'h00, 8'h01);
    run_word(8'h01, dc, ec, sc, stc, fs, fr, fb);
    checks++; if (sc !== 4) begin failures++; $display("FAIL exhaust_pulses got=%0d exp=4", sc); end
    checks++; if (ec !== 8) begin failures++; $display("FAIL exhaust_err_latency got=%0d exp=8", ec); end
    checks++; if (dc !== -1) begin failures++; $display("FAIL exhaust_no_done got=%0d exp=-1", dc); end
    checks++; if (err_mask !== 8'h01) begin failures++; $display("FAIL exhaust_err_mask got=%h exp=01", err_mask); end
    checks++; if (retry_cnt !== 4'd3) begin failures++; $display("FAIL exhaust_retry got=%0d exp=3", retry_cnt); end
    step();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL exhaust_err_one_cycle got=%b exp=0", err); end
    checks++; if (err_mask !== 8'h01) begin failures++; $display("FAIL exhaust_mask_held got=%h exp=01", err_mask); end
    preset_bank(8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_reset_mid;
    preset_bank(8'h00, 8'h00, 8'h00);
    tgt = 8'h3C; tgt_valid = 1'b1;
    step();
    tgt_valid = 1'b0;
    step();
    checks++; if (busy !== 1'b1 || s_out !== 8'h00) begin failures++; $display("FAIL midrst_in_wait got busy=%b s=%h exp=1/00", busy, s_out); end
    rst = 1'b0;
    step();
    checks++; if (s_out !== 8'h00 || r_out !== 8'h00 || busy !== 1'b0) begin failures++; $display("FAIL midrst_idle got s=%h r=%h busy=%b exp=00/00/0", s_out, r_out, busy); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL midrst_no_pulse got=%b%b exp=00", done, err); end
    rst = 1'b1;
    step();
    checks++; if (done !== 1'b0 || err !== 1'b0 || tgt_ready !== 1'b1) begin failures++; $display("FAIL midrst_after got done=%b err=%b rdy=%b exp=0/0/1", done, err, tgt_ready); end
  endtask

  task automatic test_back_to_back;
    int dcyc;
    preset_bank(8'h00, 8'h00, 8'h00);
    tgt = 8'h11; tgt_valid = 1'b1;
    step();
    tgt = 8'h22;
    dcyc = -1;
    for (int c = 1; c < 10; c++) begin
      step();
      if (done === 1'b1) begin dcyc = c; break; end
    end
    checks++; if (dcyc !== 2) begin failures++; $display("FAIL b2b_first_done got=%0d exp=2", dcyc); end
    checks++; if (tgt_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_in_done got=%b exp=1", tgt_ready); end
    step();
    tgt_valid = 1'b0;
    checks++; if (busy !== 1'b1 || s_out !== 8'h22 || r_out !== 8'h11) begin failures++; $display("FAIL b2b_second_accept got busy=%b s=%h r=%h exp=1/22/11", busy, s_out, r_out); end
    dcyc = -1;
    for (int c = 1; c < 10; c++) begin
      step();
      if (done === 1'b1) begin dcyc = c; break; end
    end
    checks++; if (dcyc !== 2) begin failures++; $display("FAIL b2b_second_done got=%0d exp=2", dcyc); end
    checks++; if (bank_q !== 8'h22) begin failures++; $display("FAIL b2b_bank_q got=%h exp=22", bank_q); end
    checks++; if (overlap_cnt !== 0) begin failures++; $display("FAIL sr_overlap got=%0d exp=0", overlap_cnt); end
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL done_err_together got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    checks = 0; failures = 0; overlap_cnt = 0; both_cnt = 0;
    rst = 1'b0; tgt = 8'h00; tgt_valid = 1'b0;
    preset_q = 8'h00; preset_ign = 8'h00; preset_stuck = 8'h00; preset_vld = 1'b1;
    test_reset();
    test_basic();
    test_no_change();
    test_retry();
    test_exhausted();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_excite_driver.md
Name: sr_excite_driver

Overview:
- Write-side controller for a bank of external SR flip-flops. It accepts a target word over a valid/ready handshake and derives per-bit set/reset excitation from the target and the bank's fed-back Q.
- It pulses S/R for one cycle, waits for the bank to settle, then verifies the fed-back Q against the target.
- On mismatch it retries up to a bounded count, then reports an error.
- It guarantees the forbidden S=R=1 combination is never driven.

Parameters:
WIDTH, 8, number of SR flip-flops driven (bits per target word)
SETTLE, 1, cycles to wait after the drive pulse before comparing feedback (must be >= 1)
MAX_RETRY, 3, additional drive attempts after the first before declaring error (0..15)

Ports:
clk  input  1  clock; all logic is on posedge clk
rst  input  1  synchronous active-low reset
tgt  input  WIDTH  target Q value for the bank
tgt_valid  input  1  tgt is valid this cycle
tgt_ready  output  1  block can accept tgt (high only in IDLE)
s_out  output  WIDTH  per-bit set strobe to the SR bank
r_out  output  WIDTH  per-bit reset strobe to the SR bank
q_fb  input  WIDTH  fed-back Q of the SR bank
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse: target reached and verified
err  output  1  one-cycle pulse: target not reached after all retries
err_mask  output  WIDTH  bits of q_fb ^ target at the failing compare; held until the next accept
retry_cnt  output  4  retries used for the current or most recent word

Behaviour:
- Reset: sampled on posedge clk when rst=0, with no asynchronous path. Reset forces:
  - state=IDLE
  - s_out=0, r_out=0, done=0, err=0, err_mask=0, retry_cnt=0
  - captured target=0
- Reset mid-operation (DRIVE or WAIT) abandons the word. s_out and r_out are 0 from the cycle after the reset edge, and no done or err is issued.
- Excitation rule, per bit i, from target t and feedback q:
  - t=1, q=0 -> S=1, R=0
  - t=0, q=1 -> S=0, R=1
  - t==q -> S=0, R=0
  - s_out & r_out == 0 in every cycle (invariant).
- States: IDLE, DRIVE, WAIT.
- IDLE:
  - tgt_ready=1, busy=0, s_out=r_out=0.
  - On an edge with tgt_valid=1: capture tgt, set retry_cnt=0, clear err_mask.
  - On that same edge, register s_out/r_out from tgt and q_fb sampled at the edge, and go to DRIVE.
- DRIVE (exactly 1 cycle):
  - s_out/r_out hold the registered excitation.
  - Next edge: s_out=r_out=0, load the settle counter with SETTLE-1, go to WAIT.
- WAIT (SETTLE cycles): s_out=r_out=0. On the edge where the counter is 0, compare q_fb with the captured target:
  - Equal: done=1 for one cycle, go to IDLE.
  - Unequal and retry_cnt < MAX_RETRY: retry_cnt+1, recompute s_out/r_out from the captured target and current q_fb, go to DRIVE.
  - Unequal and retry_cnt == MAX_RETRY: err=1 for one cycle, err_mask=q_fb^target, go to IDLE.
- Latency: done is first high SETTLE+1 cycles after the accept edge (2 cycles at default) when the first attempt succeeds. Each retry adds SETTLE+1 cycles.
- Back-to-back words: tgt_ready is high in the same cycle done or err is pulsed, so a new word may be accepted there.
- Target equal to current Q is processed normally: the DRIVE cycle has all-zero s_out/r_out and done follows on schedule. It is never skipped.
- tgt and tgt_valid are ignored outside IDLE. tgt is not required to stay stable after the accept edge.
- q_fb is treated as synchronous to clk; no synchronizer is instantiated.
- done and err are never high in the same cycle.

Test Plan:
- Reset: rst=0 for 2 edges while tgt_valid=1 -> tgt_ready=1, busy=0, s_out=r_out=0, done=err=0, no accept.
- Basic write, WIDTH=8, bank model Q follows S/R next edge: Q=8'h0F, tgt=8'hF0 -> s_out=8'hF0, r_out=8'h0F for exactly 1 cycle; done high 2 cycles after accept; retry_cnt=0; Q=8'hF0.
- No-change word: Q=8'hA5, tgt=8'hA5 -> DRIVE cycle with s_out=r_out=0; done after 2 cycles; no strobes ever high.
- Retry then success: bank ignores the first pulse on bit 3. Q=0, tgt=8'h08 -> s_out=8'h08 twice; done after 4 cycles with retry_cnt=1.
- Exhausted retries: MAX_RETRY=3, bit 0 stuck at 0, tgt=8'h01 -> 4 drive pulses; err one cycle 8 cycles after accept; err_mask=8'h01; retry_cnt=3; done never asserts.
- Reset mid-WAIT and back-to-back: rst=0 during WAIT -> no done or err, strobes 0, IDLE. Then tgt_valid held high with 8'h11 followed by 8'h22 -> second word accepted in the done cycle of the first, and s_out never overlaps r_out.
